// File: rtl/fp_adder.sv
// IEEE-754 binary32 adder, round-to-nearest-even, subnormals in and out.
// One new operand pair per cycle; the result is registered with one cycle of latency.
module fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Sum
);

    logic [31:0] sum_q, sum_d;

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_ge_b, eff_sub, res_sign;
    logic [30:0] big_mag, small_mag;
    logic [7:0]  e_big, e_small, diff;
    logic [23:0] m_big, m_small;
    logic [26:0] al_big, al_small, sh_small, keep_mask;
    logic [27:0] raw;
    logic [26:0] pre, norm;
    logic [9:0]  e_pre, e_norm, e_out;
    logic [4:0]  lzc, nsh;
    logic        round_up;
    logic [24:0] mant_r;
    logic [22:0] frac_out;

    assign a_nan   = (&A[30:23]) & (|A[22:0]);
    assign b_nan   = (&B[30:23]) & (|B[22:0]);
    assign a_inf   = (&A[30:23]) & ~(|A[22:0]);
    assign b_inf   = (&B[30:23]) & ~(|B[22:0]);
    assign a_ge_b  = (A[30:0] >= B[30:0]);
    assign eff_sub = A[31] ^ B[31];

    // Ordering by magnitude makes the datapath symmetric, so A+B == B+A bit-exactly.
    assign big_mag   = a_ge_b ? A[30:0] : B[30:0];
    assign small_mag = a_ge_b ? B[30:0] : A[30:0];
    assign res_sign  = a_ge_b ? A[31] : B[31];

    assign e_big   = (big_mag[30:23] == 8'd0) ? 8'd1 : big_mag[30:23];
    assign e_small = (small_mag[30:23] == 8'd0) ? 8'd1 : small_mag[30:23];
    assign m_big   = {|big_mag[30:23], big_mag[22:0]};
    assign m_small = {|small_mag[30:23], small_mag[22:0]};
    assign diff    = e_big - e_small;

    // Significand layout: [26:3] mantissa, [2] guard, [1] round, [0] sticky.
    always_comb begin
        al_big    = {m_big, 3'b000};
        keep_mask = {27{1'b1}} << diff;
        sh_small  = {m_small, 3'b000} >> diff;
        if (diff >= 8'd26) begin
            al_small = {26'd0, |m_small};
        end else begin
            al_small = {sh_small[26:1],
                        sh_small[0] | (|({m_small, 3'b000} & ~keep_mask))};
        end
    end

    always_comb begin
        raw = eff_sub ? ({1'b0, al_big} - {1'b0, al_small})
                      : ({1'b0, al_big} + {1'b0, al_small});
        if (raw[27]) begin
            pre   = {raw[27:2], raw[1] | raw[0]};
            e_pre = {2'b00, e_big} + 10'd1;
        end else begin
            pre   = raw[26:0];
            e_pre = {2'b00, e_big};
        end

        lzc = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (pre[i]) lzc = 5'(26 - i);
        end

        // Left-normalisation stops at exponent field 1, leaving a subnormal.
        if ({5'd0, lzc} < (e_pre - 10'd1)) nsh = lzc;
        else                               nsh = 5'(e_pre - 10'd1);
        norm   = pre << nsh;
        e_norm = e_pre - {5'd0, nsh};

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (mant_r[24]) begin
            e_out    = e_norm + 10'd1;
            frac_out = 23'd0;
        end else begin
            e_out    = mant_r[23] ? e_norm : 10'd0;
            frac_out = mant_r[22:0];
        end
    end

    always_comb begin
        if (a_nan || b_nan)              sum_d = 32'h7FC0_0000;
        else if (a_inf && b_inf)         sum_d = eff_sub ? 32'h7FC0_0000 : A;
        else if (a_inf)                  sum_d = A;
        else if (b_inf)                  sum_d = B;
        else if (mant_r == 25'd0)        sum_d = {A[31] & B[31], 31'd0};
        else if (e_out >= 10'd255)       sum_d = {res_sign, 8'hFF, 23'd0};
        else                             sum_d = {res_sign, e_out[7:0], frac_out};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) sum_q <= 32'd0;
        else        sum_q <= sum_d;
    end

    assign Sum = sum_q;

endmodule

// File: tb/tb_fp_adder.sv
// Self-checking bench for fp_adder: directed cases, reset behaviour, and
// back-to-back random pairs checked against an exact-integer reference.
module tb_fp_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, B;
    logic [31:0] Sum;

    int checks = 0;
    int errors = 0;

    fp_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Sum   (Sum)
    );

    always #5 clk = ~clk;

    // Reference: both operands become exact integers in units of 2^-149,
    // are added exactly, then rounded once to nearest-even.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic [279:0] va, vb, mag, kept, rem, half;
        logic         sign;
        int           ea, eb, p, sh, ex;
        logic [23:0]  ma, mb;
        bit a_nan, b_nan, a_inf, b_inf;
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if (a_inf && b_inf) return (a[31] != b[31]) ? 32'h7FC0_0000 : a;
        if (a_inf) return a;
        if (b_inf) return b;
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = {(a[30:23] != 0), a[22:0]};
        mb = {(b[30:23] != 0), b[22:0]};
        va = 280'(ma) << (ea - 1);
        vb = 280'(mb) << (eb - 1);
        if (a[31] == b[31]) begin
            mag = va + vb; sign = a[31];
        end else if (va >= vb) begin
            mag = va - vb; sign = a[31];
        end else begin
            mag = vb - va; sign = b[31];
        end
        if (mag == 0) return {a[31] & b[31], 31'd0};
        p = 0;
        for (int i = 0; i < 280; i++) if (mag[i]) p = i;
        if (p <= 23) return {sign, mag[30:0]};
        sh   = p - 23;
        kept = mag >> sh;
        rem  = mag - (kept << sh);
        half = 280'(1) << (sh - 1);
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        if (kept == (280'(1) << 24)) begin
            kept = kept >> 1;
            sh   = sh + 1;
        end
        ex = sh + 1;
        if (ex >= 255) return {sign, 8'hFF, 23'd0};
        return {sign, 8'(ex), kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] other, input bit near);
        int          cat, e;
        logic        s;
        logic [31:0] f;
        cat = $urandom_range(0, 15);
        s   = 1'($urandom_range(0, 1));
        f   = $urandom;
        case (cat)
            0: return {s, 31'd0};
            1: return {s, 8'd0, f[22:0]};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, f[22:0] | 23'd1};
            4: return {s, 8'hFE, f[22:0]};
            5: return {~other[31], other[30:0]};
            6: return {~other[31], other[30:0] ^ (f[30:0] & 31'h0000_00FF)};
            default: begin
                if (near) begin
                    e = int'(other[30:23]) + $urandom_range(0, 60) - 30;
                    if (e < 1)   e = 1;
                    if (e > 254) e = 254;
                end else begin
                    e = $urandom_range(1, 254);
                end
                return {s, 8'(e), f[22:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("%s A=%08h B=%08h rst_n=%0b Sum=%08h expected=%08h", tag, A, B, rst_n, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        A = a;
        B = b;
        @(posedge clk); #1;
        check(tag, Sum, exp);
    endtask

    initial begin
        logic [31:0] ra, rb, ex;
        rst_n = 1'b0;
        A = 32'h1234_5678;
        B = 32'h4000_0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", Sum, 32'h0000_0000);
        rst_n = 1'b1;

        step("add_1p0_0p5",   32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000);
        step("add_0p25_0p125",32'h3E80_0000, 32'h3E00_0000, 32'h3EC0_0000);
        step("sub_1p0_0p5",   32'h3F80_0000, 32'hBF00_0000, 32'h3F00_0000);
        step("cancel_to_p0",  32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000);
        step("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        step("overflow_inf",  32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000);
        step("tie_even",      32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000);
        step("tie_round_up",  32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002);
        step("subnormal_add", 32'h0000_0001, 32'h0000_0001, 32'h0000_0002);
        step("neg0_plus_neg0",32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
        step("pos0_plus_neg0",32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
        step("x_plus_zero",   32'hC123_4567, 32'h0000_0000, 32'hC123_4567);
        step("nan_in",        32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000);
        step("inf_plus_fin",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        step("sub_to_subnorm",32'h0080_0000, 32'h8000_0001, 32'h007F_FFFF);
        step("neg_overflow",  32'hFF7F_FFFF, 32'hFF7F_FFFF, 32'hFF80_0000);

        rst_n = 1'b0;
        step("rst_hold",      32'h3F80_0000, 32'h3F00_0000, 32'h0000_0000);
        rst_n = 1'b1;
        step("rst_release",   32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000);
        rst_n = 1'b0;
        step("rst_midstream", 32'h4040_0000, 32'h3F00_0000, 32'h0000_0000);
        rst_n = 1'b1;

        for (int i = 0; i < 1000; i++) begin
            ra = rand_op(32'h3F80_0000, 1'b0);
            rb = rand_op(ra, ($urandom_range(0, 3) != 0));
            ex = model_add(ra, rb);
            step("rand_ab", ra, rb, ex);
            step("rand_ba", rb, ra, ex);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_adder.md
FP_ADDER -- requirements
Module: fp_adder

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at IEEE-754 binary32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 A  input  32  addend, binary32 (bit 31 sign, bits 30:23 exponent with bias 127, bits 22:0 fraction).
REQ-005 B  input  32  addend, binary32, same layout as A.
REQ-006 Sum  output  32  binary32 result of A+B, driven directly from a register.

Function
REQ-007 Sum SHALL be registered with a latency of one cycle: on each rising edge with rst_n=1, Sum loads round(A+B) computed from the A and B values present before that edge.
REQ-008 The block SHALL accept a new operand pair every cycle, with no handshake and no stall.
REQ-009 Aligning exponents SHALL right-shift the smaller-magnitude significand (with hidden bit) and keep guard, round and sticky bits; shifts of 26 or more SHALL collapse into sticky.
REQ-010 Same-sign operands SHALL add significands; a carry-out SHALL renormalise by one right shift and increment the exponent.
REQ-011 Opposite-sign operands SHALL subtract the smaller magnitude from the larger, and the result SHALL take the sign of the larger magnitude.
REQ-012 After subtraction the result SHALL be left-normalised using leading-zero count; normalisation SHALL stop at exponent field 1, giving a subnormal result.
REQ-013 Rounding SHALL be round-to-nearest, ties-to-even; a mantissa carry from rounding SHALL increment the exponent.
REQ-014 Subnormal inputs (exponent 0, fraction not 0) SHALL be used with hidden bit 0 and effective exponent 1; subnormal outputs SHALL be produced (no flush-to-zero).
REQ-015 If the rounded exponent reaches 255, Sum SHALL be infinity of the result sign (0x7F800000 or 0xFF800000).
REQ-016 Special-case rules:
- Either input NaN gives 0x7FC00000.
- +inf + -inf gives 0x7FC00000.
- inf + finite value gives that inf.
- inf + inf of the same sign gives that inf.
REQ-017 Zero-result rules:
- An exact zero from opposite-sign operands gives +0 (0x00000000).
- -0 + -0 gives -0 (0x80000000).
- +0 + -0 gives +0.
REQ-018 x + 0 SHALL return x bit-exactly for any finite non-zero x.
REQ-019 The result SHALL be independent of operand order: A+B and B+A give bit-identical Sum.
REQ-020 The block SHALL raise no exception flags and have no overflow output.

Reset
REQ-021 While rst_n=0 at a rising edge, Sum SHALL load 0x00000000 and A and B are ignored.
REQ-022 On the first rising edge with rst_n=1 after reset, Sum SHALL load the result for the A and B present at that edge.
REQ-023 rst_n asserted mid-stream SHALL discard the in-flight result; no partially computed value SHALL reach Sum.

Verification
REQ-024 Simple additions, one check per line, each Sum checked one cycle after the operands are applied:
- A=0x3F800000 (1.0), B=0x3F000000 (0.5) -> Sum=0x3FC00000 (1.5).
- A=0x3E800000 (0.25), B=0x3E000000 (0.125) -> Sum=0x3EC00000 (0.375).
- A=0x3F800000 (1.0), B=0xBF000000 (-0.5) -> Sum=0x3F000000 (0.5).
REQ-025 Cancellation and special cases, one check per line:
- A=0x3F800000, B=0xBF800000 -> Sum=0x00000000.
- A=0x7F800000, B=0xFF800000 -> Sum=0x7FC00000.
- A=0x7F7FFFFF, B=0x7F7FFFFF -> Sum=0x7F800000.
REQ-026 Rounding and subnormals, one check per line:
- A=0x3F800000, B=0x33800000 (tie, even result) -> Sum=0x3F800000.
- A=0x3F800001, B=0x33800000 (tie, rounds up) -> Sum=0x3F800002.
- A=0x00000001, B=0x00000001 -> Sum=0x00000002.
REQ-027 Reset: hold rst_n=0 with A=0x3F800000 and B=0x3F000000 -> Sum=0x00000000; release rst_n -> Sum=0x3FC00000 one edge later; reassert rst_n for one edge -> Sum=0x00000000.
REQ-028 Throughput: apply a new operand pair on every cycle for 1000 random binary32 pairs; each Sum SHALL match a reference model bit-exactly, one cycle late, including swapped-operand checks.
